// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out receiver.
// Collects WIDTH serial bits (MSB-first or LSB-first, chosen on bit 0 of each
// word) and delivers completed words through a valid/ready holding register.
// A word that completes while the holding register is still occupied and not
// being drained is dropped and recorded in a sticky overrun flag.
module sipo_deserializer #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_direction,
  input  logic             i_serial_in,
  input  logic             i_frame_start,
  input  logic             i_data_ready,
  input  logic             i_clear_overrun,
  output logic [WIDTH-1:0] o_data_out,
  output logic             o_data_valid,
  output logic             o_overrun,
  output logic             o_busy,
  output logic [CW-1:0]    o_bit_count
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_sreg;
  logic             r_word_dir;
  logic [CW-1:0]    r_bit_count;
  logic             r_busy;
  logic [WIDTH-1:0] r_data_out;
  logic             r_data_valid;
  logic             r_overrun;

  state_t           w_state_next;
  logic [WIDTH-1:0] w_sreg_next;
  logic             w_word_dir_next;
  logic [CW-1:0]    w_bit_count_next;
  logic             w_busy_next;
  logic [WIDTH-1:0] w_data_out_next;
  logic             w_data_valid_next;
  logic             w_overrun_next;

  logic             w_dir;
  logic [WIDTH-1:0] w_sreg_base;
  logic [CW-1:0]    w_count_base;
  logic [WIDTH-1:0] w_shifted;
  logic             w_complete;
  logic             w_xfer;
  logic             w_drop;

  // State register: all architectural state, synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_sreg       <= {WIDTH{1'b0}};
      r_word_dir   <= 1'b0;
      r_bit_count  <= {CW{1'b0}};
      r_busy       <= 1'b0;
      r_data_out   <= {WIDTH{1'b0}};
      r_data_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_sreg       <= w_sreg_next;
      r_word_dir   <= w_word_dir_next;
      r_bit_count  <= w_bit_count_next;
      r_busy       <= w_busy_next;
      r_data_out   <= w_data_out_next;
      r_data_valid <= w_data_valid_next;
      r_overrun    <= w_overrun_next;
    end
  end

  // Next-state logic: frame_start realigns, otherwise IDLE->SHIFT on a bit and back on the last bit.
  always_comb begin
    w_state_next = r_state;
    if (i_frame_start) begin
      w_state_next = i_enable ? S_SHIFT : S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_state_next = i_enable ? S_SHIFT : S_IDLE;
        S_SHIFT: w_state_next = (i_enable && (r_bit_count == LAST_BIT)) ? S_IDLE : S_SHIFT;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Output/datapath logic: shift, count, word completion, handshake and overrun.
  always_comb begin
    // A new word starts either from IDLE or from a frame_start realignment;
    // only then is the direction input sampled.
    w_dir        = (i_frame_start || (r_state == S_IDLE)) ? i_direction : r_word_dir;
    w_sreg_base  = i_frame_start ? {WIDTH{1'b0}} : r_sreg;
    w_count_base = i_frame_start ? {CW{1'b0}} : r_bit_count;
    if (w_dir) begin
      w_shifted = {i_serial_in, w_sreg_base[WIDTH-1:1]};
    end else begin
      w_shifted = {w_sreg_base[WIDTH-2:0], i_serial_in};
    end

    w_complete = i_enable && !i_frame_start && (r_state == S_SHIFT) && (r_bit_count == LAST_BIT);
    w_xfer     = r_data_valid && i_data_ready;
    w_drop     = w_complete && r_data_valid && !i_data_ready;

    if (i_enable) begin
      w_sreg_next      = w_complete ? {WIDTH{1'b0}} : w_shifted;
      w_bit_count_next = w_complete ? {CW{1'b0}} : (w_count_base + CW'(1));
      w_word_dir_next  = w_dir;
    end else begin
      w_sreg_next      = w_sreg_base;
      w_bit_count_next = w_count_base;
      w_word_dir_next  = r_word_dir;
    end
    w_busy_next = (w_bit_count_next != {CW{1'b0}});

    // Holding register: load when empty or being drained this cycle.
    if (w_complete && !w_drop) begin
      w_data_out_next   = w_shifted;
      w_data_valid_next = 1'b1;
    end else if (w_xfer) begin
      w_data_out_next   = r_data_out;
      w_data_valid_next = 1'b0;
    end else begin
      w_data_out_next   = r_data_out;
      w_data_valid_next = r_data_valid;
    end

    // A drop takes priority over a simultaneous clear.
    if (w_drop) begin
      w_overrun_next = 1'b1;
    end else if (i_clear_overrun) begin
      w_overrun_next = 1'b0;
    end else begin
      w_overrun_next = r_overrun;
    end
  end

  assign o_data_out   = r_data_out;
  assign o_data_valid = r_data_valid;
  assign o_overrun    = r_overrun;
  assign o_busy       = r_busy;
  assign o_bit_count  = r_bit_count;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench for sipo_deserializer: directed scenarios plus a
// randomized run, all checked against a word-level reference model.
module tb_sipo_deserializer;
  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH);

  logic             clk;
  logic             reset, enable, direction, serial_in;
  logic             frame_start, data_ready, clear_overrun;
  logic [WIDTH-1:0] data_out;
  logic             data_valid, overrun, busy;
  logic [CW-1:0]    bit_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int               m_bits[$];
  logic             m_dir;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ovr;

  sipo_deserializer #(.WIDTH(WIDTH)) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_enable       (enable),
    .i_direction    (direction),
    .i_serial_in    (serial_in),
    .i_frame_start  (frame_start),
    .i_data_ready   (data_ready),
    .i_clear_overrun(clear_overrun),
    .o_data_out     (data_out),
    .o_data_valid   (data_valid),
    .o_overrun      (overrun),
    .o_busy         (busy),
    .o_bit_count    (bit_count)
  );

  initial clk = 1'b0;
  // 10 time-unit clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Word-level model: collect bits in a list, assemble the word arithmetically on completion.
  task automatic model_step(input logic en, input logic dir, input logic sin, input logic fs,
                            input logic rdy, input logic clr, input logic rst);
    logic             xfer, complete, drop;
    logic [WIDTH-1:0] word;
    if (rst) begin
      m_bits.delete();
      m_dir = 1'b0; m_data = '0; m_valid = 1'b0; m_ovr = 1'b0;
      return;
    end
    xfer = m_valid && rdy;
    complete = 1'b0;
    word = '0;
    if (fs) m_bits.delete();
    if (en) begin
      if (m_bits.size() == 0) m_dir = dir;
      m_bits.push_back(int'(sin));
      if (m_bits.size() == WIDTH) begin
        complete = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
          if (m_dir) word = word | (WIDTH'(m_bits[i]) << i);
          else       word = word | (WIDTH'(m_bits[i]) << (WIDTH - 1 - i));
        end
        m_bits.delete();
      end
    end
    drop = 1'b0;
    if (complete) begin
      if (!m_valid || xfer) begin
        m_data = word; m_valid = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (xfer) begin
      m_valid = 1'b0;
    end
    if (drop) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the clock, then compare DUT against the model.
  task automatic tick(input logic en, input logic dir, input logic sin, input logic fs,
                      input logic rdy, input logic clr, input logic rst);
    enable = en; direction = dir; serial_in = sin; frame_start = fs;
    data_ready = rdy; clear_overrun = clr; reset = rst;
    @(posedge clk);
    #1;
    model_step(en, dir, sin, fs, rdy, clr, rst);
    check("data_out",   32'(data_out),   32'(m_data));
    check("data_valid", 32'(data_valid), 32'(m_valid));
    check("overrun",    32'(overrun),    32'(m_ovr));
    check("bit_count",  32'(bit_count),  32'(m_bits.size()));
    check("busy",       32'(busy),       32'(m_bits.size() != 0));
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input logic d,
                           input logic rdy_during, input logic rdy_last);
    for (int i = 0; i < WIDTH; i++) begin
      tick(1'b1, d, d ? w[i] : w[WIDTH-1-i], 1'b0,
           (i == WIDTH - 1) ? rdy_last : rdy_during, 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] w;
    int               gap;
    logic             en, fs, rdy, clr, rst;

    // Reset state
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_data", 32'(data_out), 32'h0);
    check("reset_cnt",  32'(bit_count), 32'h0);

    // 1: MSB-first 0xA5, valid for exactly one cycle
    send_word(8'hA5, 1'b0, 1'b1, 1'b1);
    check("t1_data",  32'(data_out), 32'hA5);
    check("t1_valid", 32'(data_valid), 32'h1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t1_valid_drop", 32'(data_valid), 32'h0);

    // 2: LSB-first 0xAA, then again with direction toggled after bit 3
    send_word(8'hAA, 1'b1, 1'b1, 1'b1);
    check("t2_data", 32'(data_out), 32'hAA);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    w = 8'hAA;
    for (int i = 0; i < WIDTH; i++) tick(1'b1, (i < 3) ? 1'b1 : 1'b0, w[i], 1'b0, 1'b1, 1'b0, 1'b0);
    check("t2_toggle_data", 32'(data_out), 32'hAA);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // 3: stalled consumer, second word dropped
    send_word(8'h3C, 1'b0, 1'b0, 1'b0);
    send_word(8'hFF, 1'b0, 1'b0, 1'b0);
    check("t3_data",  32'(data_out), 32'h3C);
    check("t3_valid", 32'(data_valid), 32'h1);
    check("t3_ovr",   32'(overrun), 32'h1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t3_drain", 32'(data_valid), 32'h0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t3_clear", 32'(overrun), 32'h0);

    // 4: back-to-back, transfer coincides with completion
    send_word(8'h12, 1'b0, 1'b0, 1'b0);
    check("t4_first", 32'(data_out), 32'h12);
    send_word(8'h34, 1'b0, 1'b0, 1'b1);
    check("t4_second", 32'(data_out), 32'h34);
    check("t4_valid",  32'(data_valid), 32'h1);
    check("t4_ovr",    32'(overrun), 32'h0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // 5: three bits, then frame_start carrying bit 0 of 0xC3
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    w = 8'hC3;
    tick(1'b1, 1'b0, w[7], 1'b1, 1'b1, 1'b0, 1'b0);
    check("t5_cnt", 32'(bit_count), 32'h1);
    for (int i = 6; i >= 0; i--) tick(1'b1, 1'b0, w[i], 1'b0, 1'b1, 1'b0, 1'b0);
    check("t5_data", 32'(data_out), 32'hC3);

    // 6: gapped bits, reset after 5 bits, then 0x5A
    w = 8'h96;
    for (int i = 0; i < 5; i++) begin
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0, w[7-i], 1'b0, 1'b0, 1'b0, 1'b0);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t6_rst_data",  32'(data_out), 32'h0);
    check("t6_rst_valid", 32'(data_valid), 32'h0);
    check("t6_rst_busy",  32'(busy), 32'h0);
    w = 8'h5A;
    for (int i = 0; i < WIDTH; i++) begin
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0, w[7-i], 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("t6_data", 32'(data_out), 32'h5A);

    // Randomized run
    for (int n = 0; n < 3000; n++) begin
      en  = ($urandom_range(0, 9) < 7);
      fs  = ($urandom_range(0, 39) == 0);
      rdy = ($urandom_range(0, 1) == 1);
      clr = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 199) == 0);
      tick(en, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), fs, rdy, clr, rst);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
